// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
//   Data-memory/IO access unit between a single-cycle datapath and a slow
//   request/ack data bus. A load or store from the execute stage starts one bus
//   transaction. The datapath is held with stall until the access completes.
//   The load result is returned on read_data. It stays stable during the
//   one-cycle DONE state, which is when the instruction retires.
//
// Ports
//   clock       in   1   rising-edge clock
//   reset       in   1   asynchronous, active-low reset
//   MemRead     in   1   load request
//   MemWrite    in   1   store request
//   ALU_result  in   32  byte address
//   write_data  in   32  store data
//   read_data   out  32  load result (holds until the next load completes)
//   stall       out  1   hold PC / suppress RegWrite (combinational)
//   bus_req     out  1   bus transaction request
//   bus_we      out  1   1 = write, 0 = read
//   bus_addr    out  30  word address
//   bus_wdata   out  32  store data
//   bus_ack     in   1   one-cycle completion pulse
//   bus_rdata   in   32  read data, valid with bus_ack
//   err         out  1   sticky error (misaligned, read+write, timeout)
// ---------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALU_result,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r, next_state_s;
  logic [CW-1:0] count_r, count_s;
  logic [31:0]   read_data_s;
  logic          bus_req_s, bus_we_s, err_s, stall_s;
  logic [29:0]   bus_addr_s;
  logic [31:0]   bus_wdata_s;

  // Next-state and next-register-value logic
  always_comb begin
    next_state_s = state_r;
    count_s      = count_r;
    read_data_s  = read_data;
    bus_req_s    = bus_req;
    bus_we_s     = bus_we;
    bus_addr_s   = bus_addr;
    bus_wdata_s  = bus_wdata;
    err_s        = err;
    stall_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (MemRead || MemWrite) begin
          stall_s = 1'b1;
          if (ALU_result[1:0] != 2'b00) begin
            // Misaligned: no bus access; a load returns zero.
            err_s = 1'b1;
            if (MemRead) begin
              read_data_s = 32'h0000_0000;
            end else begin
              read_data_s = read_data;
            end
            next_state_s = ST_DONE;
          end else begin
            bus_addr_s  = ALU_result[31:2];
            bus_wdata_s = write_data;
            // A combined read+write request is performed as a write only.
            bus_we_s    = MemWrite;
            if (MemRead && MemWrite) begin
              err_s = 1'b1;
            end else begin
              err_s = err;
            end
            bus_req_s    = 1'b1;
            count_s      = {CW{1'b0}};
            next_state_s = ST_BUS;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        stall_s = 1'b1;
        // Ack has priority over a timeout that lands on the same cycle.
        if (bus_ack) begin
          bus_req_s = 1'b0;
          if (!bus_we) begin
            read_data_s = bus_rdata;
          end else begin
            read_data_s = read_data;
          end
          next_state_s = ST_DONE;
        end else if (count_r == LAST_CNT) begin
          bus_req_s = 1'b0;
          err_s     = 1'b1;
          if (!bus_we) begin
            read_data_s = ERR_DATA;
          end else begin
            read_data_s = read_data;
          end
          next_state_s = ST_DONE;
        end else begin
          count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        // Requests are ignored here so every access retires exactly once.
        next_state_s = ST_IDLE;
      end
      default: begin
        bus_req_s    = 1'b0;
        next_state_s = ST_IDLE;
      end
    endcase
  end

  assign stall = stall_s;

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      count_r   <= {CW{1'b0}};
      read_data <= 32'h0000_0000;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 30'h0000_0000;
      bus_wdata <= 32'h0000_0000;
      err       <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      count_r   <= count_s;
      read_data <= read_data_s;
      bus_req   <= bus_req_s;
      bus_we    <= bus_we_s;
      bus_addr  <= bus_addr_s;
      bus_wdata <= bus_wdata_s;
      err       <= err_s;
    end
  end

endmodule
